// File: rtl/scanchain_pkg.sv
// Shared definitions for the scan chain shifter: FSM state encoding and frame sizing.
package scanchain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHIFT      = 2'd1,
        ST_UPDATE     = 2'd2,
        ST_RESET_HOLD = 2'd3
    } state_t;

    // The frame is the payload concatenated above the address.
    function automatic int frame_bits(input int addr_bits, input int payload_bits);
        return addr_bits + payload_bits;
    endfunction

endpackage

// File: rtl/scanchain_clkgen.sv
// Scan clock divider: while enabled, scan_clk toggles every CLK_DIV clk cycles.
// rise_tick/fall_tick flag the cycle just before scan_clk goes high/low.
module scanchain_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic rise_tick,
    output logic fall_tick,
    output logic scan_clk
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic             wrap;

    assign wrap      = enable && (div_cnt_reg == DIV_LAST);
    assign rise_tick = wrap && !scan_clk;
    assign fall_tick = wrap && scan_clk;

    // Disabling parks the divider at the start of a low phase.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_reg <= '0;
            scan_clk    <= 1'b0;
        end else if (!enable) begin
            div_cnt_reg <= '0;
            scan_clk    <= 1'b0;
        end else if (wrap) begin
            div_cnt_reg <= '0;
            scan_clk    <= !scan_clk;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/scanchain_shifter.sv
// Serializes accepted write commands onto the chip scan chain, then strobes scan_update;
// reset commands hold scan_reset instead. Optional readback capture: SCANCHAIN_READBACK_EN.
module scanchain_shifter
    import scanchain_pkg::*;
#(
    parameter int ADDR_BITS    = 12,
    parameter int PAYLOAD_BITS = 169,
    parameter int CLK_DIV      = 4,
    parameter int RESET_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    write_valid,
    output logic                    write_ready,
    input  logic [ADDR_BITS-1:0]    write_addr,
    input  logic [PAYLOAD_BITS-1:0] write_payload,
    input  logic                    write_reset,
    output logic                    scan_clk,
    output logic                    scan_in,
    output logic                    scan_update,
    output logic                    scan_reset
`ifdef SCANCHAIN_READBACK_EN
    ,
    input  logic                              scan_out,
    output logic [ADDR_BITS+PAYLOAD_BITS-1:0] read_data,
    output logic                              read_valid
`endif
);

    localparam int FRAME_BITS = frame_bits(ADDR_BITS, PAYLOAD_BITS);
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int RST_W      = $clog2(RESET_CYCLES + 1);
    localparam int UPD_W      = $clog2(2 * CLK_DIV);

    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(FRAME_BITS);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(2 * CLK_DIV - 1);

    state_t                state_reg;
    logic [FRAME_BITS-1:0] shift_data_reg;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic [RST_W-1:0]      rst_cnt_reg;
    logic [UPD_W-1:0]      upd_cnt_reg;

    logic shift_en;
    logic rise_tick;
    logic fall_tick;
    logic shift_done;

    assign write_ready = (state_reg == ST_IDLE);
    assign shift_en    = (state_reg == ST_SHIFT);
    // The bit on scan_in is always the MSB of the shift register, which is cleared in IDLE.
    assign scan_in     = shift_data_reg[FRAME_BITS-1];
    assign shift_done  = fall_tick && (bit_cnt_reg == BIT_FULL);

    scanchain_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (shift_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .scan_clk  (scan_clk)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            shift_data_reg <= '0;
            bit_cnt_reg    <= '0;
            rst_cnt_reg    <= '0;
            upd_cnt_reg    <= '0;
            scan_update    <= 1'b0;
            scan_reset     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    scan_update <= 1'b0;
                    scan_reset  <= 1'b0;
                    if (write_valid) begin
                        if (write_reset) begin
                            state_reg   <= ST_RESET_HOLD;
                            scan_reset  <= 1'b1;
                            rst_cnt_reg <= '0;
                        end else begin
                            state_reg      <= ST_SHIFT;
                            shift_data_reg <= {write_payload, write_addr};
                            bit_cnt_reg    <= '0;
                        end
                    end
                end

                ST_SHIFT: begin
                    // Bits are counted on the rising half; the falling half advances or finishes.
                    if (rise_tick) begin
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                    end
                    if (shift_done) begin
                        state_reg   <= ST_UPDATE;
                        scan_update <= 1'b1;
                        upd_cnt_reg <= '0;
                    end else if (fall_tick) begin
                        shift_data_reg <= {shift_data_reg[FRAME_BITS-2:0], 1'b0};
                    end
                end

                ST_UPDATE: begin
                    if (upd_cnt_reg == UPD_LAST) begin
                        state_reg      <= ST_IDLE;
                        scan_update    <= 1'b0;
                        shift_data_reg <= '0;
                    end else begin
                        upd_cnt_reg <= upd_cnt_reg + UPD_W'(1);
                    end
                end

                ST_RESET_HOLD: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        state_reg  <= ST_IDLE;
                        scan_reset <= 1'b0;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + RST_W'(1);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SCANCHAIN_READBACK_EN
    logic [FRAME_BITS-1:0] capture_reg;

    // The chip's scan_out is sampled on the same cycle scan_clk rises.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            capture_reg <= '0;
            read_data   <= '0;
            read_valid  <= 1'b0;
        end else begin
            read_valid <= shift_done;
            if (rise_tick) begin
                capture_reg <= {capture_reg[FRAME_BITS-2:0], scan_out};
            end
            if (shift_done) begin
                read_data <= capture_reg;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scanchain_shifter.sv
// Randomized self-checking bench for scanchain_shifter against a behavioural command model.
module tb_scanchain_shifter;

    localparam int AB = 4;
    localparam int PB = 4;
    localparam int CD = 2;
    localparam int RC = 5;
    localparam int FB = AB + PB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          write_valid = 1'b0;
    logic          write_ready;
    logic [AB-1:0] write_addr = '0;
    logic [PB-1:0] write_payload = '0;
    logic          write_reset = 1'b0;
    logic          scan_clk;
    logic          scan_in;
    logic          scan_update;
    logic          scan_reset;
`ifdef SCANCHAIN_READBACK_EN
    logic          scan_out = 1'b0;
    logic [FB-1:0] read_data;
    logic          read_valid;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the chip's scan chain: an FB-bit shift register clocked by scan_clk rises.
    logic [FB-1:0] chain = 8'h96;
    logic          chain_sclk_prev = 1'b0;

    always #5 clk = ~clk;

    scanchain_shifter #(
        .ADDR_BITS    (AB),
        .PAYLOAD_BITS (PB),
        .CLK_DIV      (CD),
        .RESET_CYCLES (RC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .write_valid   (write_valid),
        .write_ready   (write_ready),
        .write_addr    (write_addr),
        .write_payload (write_payload),
        .write_reset   (write_reset),
        .scan_clk      (scan_clk),
        .scan_in       (scan_in),
        .scan_update   (scan_update),
        .scan_reset    (scan_reset)
`ifdef SCANCHAIN_READBACK_EN
        ,
        .scan_out      (scan_out),
        .read_data     (read_data),
        .read_valid    (read_valid)
`endif
    );

    always @(negedge clk) begin
        if (scan_clk && !chain_sclk_prev) chain = {chain[FB-2:0], scan_in};
        chain_sclk_prev = scan_clk;
`ifdef SCANCHAIN_READBACK_EN
        scan_out = chain[FB-1];
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command and observe it until write_ready returns. Caller is at a negedge.
    task automatic run_cmd(input logic is_rst, input logic [AB-1:0] a, input logic [PB-1:0] p,
                           input bit mutate, input bit keep_valid);
        logic [FB-1:0] frame;
        logic [FB-1:0] got_bits;
        logic [FB-1:0] exp_rd;
        logic          prev_sclk;
        logic          prev_upd;
        int rises, upd, upd_pulses, rst_hi, clk_hi, lat, wait_c;
        int rv, rv_cyc, upd_cyc;
        frame = {p, a};
        got_bits = '0;
        prev_sclk = 1'b0;
        prev_upd = 1'b0;
        rises = 0; upd = 0; upd_pulses = 0; rst_hi = 0; clk_hi = 0; lat = -1; wait_c = 0;
        rv = 0; rv_cyc = -1; upd_cyc = -1;
        while (!write_ready && wait_c < 100) begin
            @(negedge clk);
            wait_c++;
        end
        check("ready_before_accept", {31'd0, write_ready}, 32'd1);
        exp_rd = chain;
        write_valid = 1'b1;
        write_reset = is_rst;
        write_addr = a;
        write_payload = p;
        @(posedge clk);
        for (int cyc = 0; cyc < 200 && lat < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("ready_low_after_accept", {31'd0, write_ready}, 32'd0);
                if (!keep_valid) write_valid = 1'b0;
            end
            if (mutate) begin
                write_addr = AB'($urandom);
                write_payload = PB'($urandom);
                write_reset = 1'($urandom);
            end
            if (write_ready) begin
                lat = cyc;
            end else begin
                if (scan_clk && !prev_sclk) begin
                    if (rises < FB) got_bits[FB-1-rises] = scan_in;
                    rises++;
                end
                if (scan_update && !prev_upd) upd_pulses++;
                if (scan_update && upd_cyc < 0) upd_cyc = cyc;
                prev_sclk = scan_clk;
                prev_upd = scan_update;
                if (scan_clk) clk_hi++;
                if (scan_update) upd++;
                if (scan_reset) rst_hi++;
`ifdef SCANCHAIN_READBACK_EN
                if (read_valid) begin
                    rv++;
                    rv_cyc = cyc;
                    check("read_data", 32'(read_data), 32'(exp_rd));
                end
`endif
            end
        end
        check("ready_latency", lat, is_rst ? RC : 2 * CD * (FB + 1));
        check("idle_outputs", {28'd0, scan_clk, scan_in, scan_update, scan_reset}, 32'd0);
        check("scan_clk_rises", rises, is_rst ? 0 : FB);
        check("scan_clk_high_cycles", clk_hi, is_rst ? 0 : CD * FB);
        check("update_cycles", upd, is_rst ? 0 : 2 * CD);
        check("update_pulses", upd_pulses, is_rst ? 0 : 1);
        check("scan_reset_cycles", rst_hi, is_rst ? RC : 0);
        if (!is_rst) check("shifted_frame", 32'(got_bits), 32'(frame));
`ifdef SCANCHAIN_READBACK_EN
        check("read_valid_pulses", rv, is_rst ? 0 : 1);
        if (!is_rst) check("read_valid_at_update", rv_cyc, upd_cyc);
`endif
        $display("[TB] cmd rst=%0b addr=%h payload=%h mutate=%0b b2b=%0b latency=%0d bits=%h",
                 is_rst, a, p, mutate, keep_valid, lat, got_bits);
    endtask

    initial begin
        int rises;
        int guard;
        int stray;
        logic prev_sclk;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, scan_clk, scan_in, scan_update, scan_reset}, 32'd0);
        check("reset_ready", {31'd0, write_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed: basic shift, reset command, back-to-back with valid held high.
        run_cmd(1'b0, 4'hA, 4'h5, 1'b0, 1'b0);
        run_cmd(1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
        run_cmd(1'b0, 4'hC, 4'h3, 1'b0, 1'b1);
        run_cmd(1'b0, 4'h3, 4'hC, 1'b0, 1'b0);

        // Abort a frame with reset_n while bit 3 is on scan_in.
        write_valid = 1'b1; write_reset = 1'b0; write_addr = 4'h6; write_payload = 4'h9;
        @(posedge clk);
        @(negedge clk);
        write_valid = 1'b0;
        rises = 0; guard = 0; prev_sclk = 1'b0;
        while (rises < 3 && guard < 100) begin
            if (scan_clk && !prev_sclk) rises++;
            prev_sclk = scan_clk;
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (scan_clk && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached_bit3", rises, 3);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_outputs", {28'd0, scan_clk, scan_in, scan_update, scan_reset}, 32'd0);
        reset_n = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (scan_update || scan_clk || !write_ready) stray++;
        end
        check("abort_quiet_idle", stray, 0);
        run_cmd(1'b0, 4'hF, 4'hF, 1'b0, 1'b0);

        // Reset wins over a simultaneous acceptance.
        write_valid = 1'b1; write_reset = 1'b1; reset_n = 1'b0;
        @(negedge clk);
        check("reset_beats_accept", {30'd0, write_ready, scan_reset}, 32'd2);
        write_valid = 1'b0; write_reset = 1'b0; reset_n = 1'b1;
        @(negedge clk);

        // Inputs scrambled every cycle while busy.
        repeat (3) run_cmd(1'b0, AB'($urandom), PB'($urandom), 1'b1, 1'b0);

        // Random mix of commands, some back-to-back.
        for (int i = 0; i < 12; i++) begin
            logic r;
            bit   keep;
            bit   mut;
            r = ($urandom_range(0, 3) == 0);
            keep = (i < 11) && ($urandom_range(0, 1) == 1);
            mut = !keep && ($urandom_range(0, 1) == 1);
            run_cmd(r, AB'($urandom), PB'($urandom), mut, keep);
        end
        write_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
